// File: rtl/uart_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : uart_prog_loader
// Description : Boot loader that turns the uart_rx byte stream into nibble
//               writes for the 4-bit CPU program memory.
//               Frame: HEADER_BYTE, length N, N data bytes, optional checksum.
//               Each data byte becomes two writes: high nibble at address 2k,
//               low nibble at 2k+1. The CPU is held halted while a frame is
//               loading and after any aborted frame.
// Option      : UART_PROG_LOADER_CHECKSUM_EN - when defined, a checksum byte
//               (XOR of all data bytes) follows the data and must match.
// Ports       : clk_i / reset_i          clock, synchronous active-high reset
//               rx_data_i                received byte from uart_rx
//               rx_valid_strb_i          1-cycle strobe, rx_data_i valid
//               mem_we_o                 program memory write enable
//               mem_addr_o               nibble write address
//               mem_data_o               nibble write data
//               cpu_halt_o               hold CPU in reset while 1
//               busy_o                   frame in progress
//               load_done_strb_o         1-cycle strobe, frame accepted
//               load_err_strb_o          1-cycle strobe, frame aborted
// Revision    : 1.0 - initial release
// ============================================================================
module uart_prog_loader #(
    parameter int                          UART_DATA_LENGTH = 8,
    parameter int                          MEM_ADDR_WIDTH   = 8,
    parameter logic [UART_DATA_LENGTH-1:0] HEADER_BYTE      = 8'hA5,
    parameter int                          TIMEOUT_CYCLES   = 60000,
    parameter int                          TIMEOUT_BITWIDTH = 16
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [UART_DATA_LENGTH-1:0] rx_data_i,
    input  logic                        rx_valid_strb_i,
    output logic                        mem_we_o,
    output logic [MEM_ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [3:0]                  mem_data_o,
    output logic                        cpu_halt_o,
    output logic                        busy_o,
    output logic                        load_done_strb_o,
    output logic                        load_err_strb_o
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_LEN   = 3'd1;
    localparam logic [2:0] c_ST_DATA  = 3'd2;
    localparam logic [2:0] c_ST_WR_HI = 3'd3;
    localparam logic [2:0] c_ST_WR_LO = 3'd4;
`ifdef UART_PROG_LOADER_CHECKSUM_EN
    localparam logic [2:0] c_ST_CHK   = 3'd5;
`endif

    // Longest frame that still fits memory without the address wrapping.
    localparam logic [31:0] c_MAX_LEN = 32'(2 ** (MEM_ADDR_WIDTH - 1));
    localparam logic [TIMEOUT_BITWIDTH-1:0] c_TO_LAST = TIMEOUT_BITWIDTH'(TIMEOUT_CYCLES - 1);

    logic [2:0]                  r_state;
    logic [2:0]                  w_state_nxt;
    logic                        r_mem_we;
    logic [MEM_ADDR_WIDTH-1:0]   r_mem_addr;
    logic [3:0]                  r_mem_data;
    logic                        r_halt;
    logic                        r_done;
    logic                        r_err;
    logic [UART_DATA_LENGTH-1:0] r_remain;   // data bytes still to receive
    logic [MEM_ADDR_WIDTH-2:0]   r_idx;      // byte index k
    logic [3:0]                  r_lo_nib;   // low nibble waiting for WR_LO
    logic [TIMEOUT_BITWIDTH-1:0] r_to_cnt;
`ifdef UART_PROG_LOADER_CHECKSUM_EN
    logic [UART_DATA_LENGTH-1:0] r_xor;
`endif

    logic                        w_we;
    logic [MEM_ADDR_WIDTH-1:0]   w_addr_nxt;
    logic [3:0]                  w_data_nxt;
    logic                        w_halt_nxt;
    logic                        w_done;
    logic                        w_err;
    logic                        w_len_ld;
    logic                        w_byte_ld;
    logic                        w_idx_inc;
    logic                        w_len_too_big;
    logic                        w_to_expired;
    logic                        w_counting;

    assign w_len_too_big = 32'(rx_data_i) > c_MAX_LEN;
    assign w_to_expired  = (r_to_cnt == c_TO_LAST);
`ifdef UART_PROG_LOADER_CHECKSUM_EN
    assign w_counting = (r_state == c_ST_LEN) || (r_state == c_ST_DATA) || (r_state == c_ST_CHK);
`else
    assign w_counting = (r_state == c_ST_LEN) || (r_state == c_ST_DATA);
`endif

    // ------------------------------------------------------------------
    // Next-state and next-output logic. Strobe outputs and the memory
    // write port are registered, so each appears the cycle after the
    // decision made here.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        w_addr_nxt  = r_mem_addr;
        w_data_nxt  = r_mem_data;
        w_halt_nxt  = r_halt;
        w_done      = 1'b0;
        w_err       = 1'b0;
        w_len_ld    = 1'b0;
        w_byte_ld   = 1'b0;
        w_idx_inc   = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                if (rx_valid_strb_i && (rx_data_i == HEADER_BYTE)) begin
                    w_state_nxt = c_ST_LEN;
                    w_halt_nxt  = 1'b1;
                end
            end
            c_ST_LEN: begin
                if (rx_valid_strb_i) begin
                    if (rx_data_i == '0) begin
`ifdef UART_PROG_LOADER_CHECKSUM_EN
                        w_state_nxt = c_ST_CHK;
`else
                        w_done = 1'b1;
`endif
                    end else if (w_len_too_big) begin
                        w_err = 1'b1;
                    end else begin
                        w_len_ld    = 1'b1;
                        w_state_nxt = c_ST_DATA;
                    end
                end else if (w_to_expired) begin
                    w_err = 1'b1;
                end
            end
            c_ST_DATA: begin
                if (rx_valid_strb_i) begin
                    w_byte_ld   = 1'b1;
                    w_state_nxt = c_ST_WR_HI;
                    w_we        = 1'b1;
                    w_addr_nxt  = {r_idx, 1'b0};
                    w_data_nxt  = rx_data_i[7:4];
                end else if (w_to_expired) begin
                    w_err = 1'b1;
                end
            end
            c_ST_WR_HI: begin
                w_state_nxt = c_ST_WR_LO;
                w_we        = 1'b1;
                w_addr_nxt  = {r_idx, 1'b1};
                w_data_nxt  = r_lo_nib;
            end
            c_ST_WR_LO: begin
                w_idx_inc = 1'b1;
                if (r_remain == UART_DATA_LENGTH'(1)) begin
`ifdef UART_PROG_LOADER_CHECKSUM_EN
                    w_state_nxt = c_ST_CHK;
`else
                    w_done = 1'b1;
`endif
                end else begin
                    w_state_nxt = c_ST_DATA;
                end
            end
`ifdef UART_PROG_LOADER_CHECKSUM_EN
            c_ST_CHK: begin
                if (rx_valid_strb_i) begin
                    if (rx_data_i == r_xor) begin
                        w_done = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end else if (w_to_expired) begin
                    w_err = 1'b1;
                end
            end
`endif
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase

        // Done releases the CPU; error keeps it halted since memory is stale.
        if (w_done) begin
            w_state_nxt = c_ST_IDLE;
            w_halt_nxt  = 1'b0;
        end
        if (w_err) begin
            w_state_nxt = c_ST_IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state    <= c_ST_IDLE;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_halt     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_remain   <= '0;
            r_idx      <= '0;
            r_lo_nib   <= '0;
            r_to_cnt   <= '0;
`ifdef UART_PROG_LOADER_CHECKSUM_EN
            r_xor      <= '0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_mem_we   <= w_we;
            r_mem_addr <= w_addr_nxt;
            r_mem_data <= w_data_nxt;
            r_halt     <= w_halt_nxt;
            r_done     <= w_done;
            r_err      <= w_err;

            if (w_len_ld) begin
                r_remain <= rx_data_i;
                r_idx    <= '0;
            end else if (w_idx_inc) begin
                r_remain <= r_remain - 1'b1;
                r_idx    <= r_idx + 1'b1;
            end

            if (w_byte_ld) begin
                r_lo_nib <= rx_data_i[3:0];
            end

`ifdef UART_PROG_LOADER_CHECKSUM_EN
            // Cleared while idle so an N==0 frame expects a 0x00 checksum.
            if (r_state == c_ST_IDLE) begin
                r_xor <= '0;
            end else if (w_byte_ld) begin
                r_xor <= r_xor ^ rx_data_i;
            end
`endif

            // Inter-byte timeout: holds during the write states, saturates.
            if ((r_state == c_ST_IDLE) || rx_valid_strb_i) begin
                r_to_cnt <= '0;
            end else if (w_counting && !w_to_expired) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

    assign mem_we_o         = r_mem_we;
    assign mem_addr_o       = r_mem_addr;
    assign mem_data_o       = r_mem_data;
    assign cpu_halt_o       = r_halt;
    assign busy_o           = (r_state != c_ST_IDLE);
    assign load_done_strb_o = r_done;
    assign load_err_strb_o  = r_err;

endmodule
`default_nettype wire
